// File: rtl/isa_pkg.sv
// Shared ISA definitions: field widths, instruction-register field positions
// and the fetch FSM state encoding.
package isa_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 3;
  localparam int IIMM_W   = 6;
  localparam int JIMM_W   = 12;
  localparam int INSTR_W  = 16;

  // Field positions as decoded by the instruction register
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RS_MSB   = 11;
  localparam int RS_LSB   = 9;
  localparam int RT_MSB   = 8;
  localparam int RT_LSB   = 6;
  localparam int RD_MSB   = 5;
  localparam int RD_LSB   = 3;
  localparam int FUNK_MSB = 2;
  localparam int FUNK_LSB = 0;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel. A read is offered while mem_req is high and
// completes on the first rising edge where mem_req and mem_ready are both high;
// mem_addr is held stable for the whole request and mem_rdata is valid with mem_ready.
interface instruction_fetch_unit_if #(
  parameter int PC_W = 16
);
  import isa_pkg::*;

  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect target: jump keeps the upper PC bits, branch adds a
// sign-extended word offset with modulo-2^PC_W wrap. Jump wins over branch.
module pc_target_calc
  import isa_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [IIMM_W-1:0] iImm,
  input  logic [JIMM_W-1:0] jImm,
  input  logic              branch_take,
  input  logic              jump_take,
  output logic [PC_W-1:0]   target,
  output logic              redirect
);

  logic [PC_W-1:0] branch_tgt;
  logic [PC_W-1:0] jump_tgt;

  assign branch_tgt = pc + {{(PC_W-IIMM_W){iImm[IIMM_W-1]}}, iImm};
  assign jump_tgt   = {pc[PC_W-1:JIMM_W], jImm};

  always_comb begin
    target   = pc;
    redirect = 1'b0;
    if (jump_take) begin
      target   = jump_tgt;
      redirect = 1'b1;
    end else if (branch_take) begin
      target   = branch_tgt;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter plus single-outstanding instruction fetch. Each accepted word
// is presented on IR_in with a one-cycle IRWrite strobe for the instruction register.
module instruction_fetch_unit
  import isa_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fetch_start,
  input  logic                branch_take,
  input  logic [IIMM_W-1:0]   iImm,
  input  logic                jump_take,
  input  logic [JIMM_W-1:0]   jImm,
  instruction_fetch_unit_if.master mem,
  output logic [INSTR_W-1:0]  IR_in,
  output logic                IRWrite,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic [0:0]          state_dbg,
  output logic                redir_pend_dbg
);

  localparam logic [0:0] S_IDLE = FETCH_IDLE;
  localparam logic [0:0] S_REQ  = FETCH_REQ;

  logic [0:0]         state;
  logic [PC_W-1:0]    pc_q;
  logic               mem_req_q;
  logic [PC_W-1:0]    mem_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               irw_q;
  logic               busy_q;
  logic               redir_pend;
  logic [PC_W-1:0]    redir_pc;

  logic [PC_W-1:0]    target;
  logic               redirect;
  logic [PC_W-1:0]    pc_next;

  // One calculator serves both the IDLE update and the REQ-time latch; in both
  // cases the base is the current pc register.
  pc_target_calc #(
    .PC_W (PC_W)
  ) u_calc (
    .pc          (pc_q),
    .iImm        (iImm),
    .jImm        (jImm),
    .branch_take (branch_take),
    .jump_take   (jump_take),
    .target      (target),
    .redirect    (redirect)
  );

  assign pc_next = redirect ? target : pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      irw_q      <= 1'b0;
      busy_q     <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      irw_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            mem_addr_q <= pc_next;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_REQ;
          end else begin
            pc_q <= pc_next;
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            redir_pend <= 1'b0;
            state      <= S_IDLE;
            // A redirect arriving on the completion edge counts as the latest one
            if (redirect) begin
              pc_q <= target;
            end else if (redir_pend) begin
              pc_q <= redir_pc;
            end else begin
              ir_q  <= mem.mem_rdata;
              irw_q <= 1'b1;
              pc_q  <= mem_addr_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
          end else if (redirect) begin
            redir_pc   <= target;
            redir_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req     = mem_req_q;
  assign mem.mem_addr    = mem_addr_q;
  assign IR_in           = ir_q;
  assign IRWrite         = irw_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign state_dbg       = state;
  assign redir_pend_dbg  = redir_pend;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: negedge-driven stimulus, a wait-state
// memory responder and expected-address / expected-word queues.
module tb_instruction_fetch_unit;
  import isa_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        fetch_start;
  logic        branch_take;
  logic [5:0]  iImm;
  logic        jump_take;
  logic [11:0] jImm;
  logic [15:0] IR_in;
  logic        IRWrite;
  logic [15:0] pc;
  logic        busy;
  logic [0:0]  state_dbg;
  logic        redir_pend_dbg;

  instruction_fetch_unit_if #(.PC_W(16)) mem_if ();

  instruction_fetch_unit #(
    .PC_W     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_start    (fetch_start),
    .branch_take    (branch_take),
    .iImm           (iImm),
    .jump_take      (jump_take),
    .jImm           (jImm),
    .mem            (mem_if.master),
    .IR_in          (IR_in),
    .IRWrite        (IRWrite),
    .pc             (pc),
    .busy           (busy),
    .state_dbg      (state_dbg),
    .redir_pend_dbg (redir_pend_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_ir_q[$];
  logic [15:0] exp_addr_q[$];
  int          irw_cycles[$];
  int          irw_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        req_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- memory responder ----------------
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        ready_tied = 1'b0;
  logic [15:0] base_word = 16'h1A2B;

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 16'h0000;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      wait_cnt         = 0;
      mem_if.mem_ready = 1'b0;
    end else if (ready_tied) begin
      mem_if.mem_ready = 1'b1;
      mem_if.mem_rdata = base_word + mem_if.mem_addr;
    end else if (mem_if.mem_req) begin
      if (wait_cnt >= mem_wait) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = base_word + mem_if.mem_addr;
      end else begin
        mem_if.mem_ready = 1'b0;
        wait_cnt         = wait_cnt + 1;
      end
    end else begin
      mem_if.mem_ready = 1'b0;
      wait_cnt         = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_if.mem_req && !req_prev) begin
        if (exp_addr_q.size() == 0) check("addr_unexpected_req", 32'd1, 32'd0);
        else check("mem_addr", {16'h0, mem_if.mem_addr}, {16'h0, exp_addr_q.pop_front()});
      end
      if (IRWrite) begin
        irw_count <= irw_count + 1;
        irw_cycles.push_back(cyc);
        if (exp_ir_q.size() == 0) check("irwrite_unexpected", 32'd1, 32'd0);
        else check("ir_in", {16'h0, IR_in}, {16'h0, exp_ir_q.pop_front()});
      end
    end
    req_prev <= mem_if.mem_req;
  end

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic do_reset();
    reset_n    = 1'b0;
    ready_tied = 1'b0;
    mem_wait   = 0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pc",       {16'h0, pc}, 32'h0);
    check("rst_mem_req",  {31'h0, mem_if.mem_req}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_if.mem_addr}, 32'h0);
    check("rst_ir_in",    {16'h0, IR_in}, 32'h0);
    check("rst_irwrite",  {31'h0, IRWrite}, 32'h0);
    check("rst_busy",     {31'h0, busy}, 32'h0);
    check("rst_state",    {31'h0, state_dbg}, 32'h0);
    check("rst_redir",    {31'h0, redir_pend_dbg}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic drive_redirect(input logic br, input logic [5:0] ii,
                                input logic jp, input logic [11:0] jj);
    branch_take = br; iImm = ii; jump_take = jp; jImm = jj;
    @(negedge clock);
    branch_take = 1'b0; jump_take = 1'b0;
  endtask

  task automatic fetch_issue(input logic [15:0] exp_addr, input logic expect_ir,
                             input logic jp, input logic [11:0] jj);
    exp_addr_q.push_back(exp_addr);
    if (expect_ir) exp_ir_q.push_back(base_word + exp_addr);
    fetch_start = 1'b1; jump_take = jp; jImm = jj;
    @(negedge clock);
    fetch_start = 1'b0; jump_take = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    check("idle_wait", {31'h0, busy}, 32'h0);
    #1;
  endtask

  // ---------------- test sequence ----------------
  logic [15:0] ir_before;
  int          irw_before;

  initial begin
    fetch_start = 1'b0; branch_take = 1'b0; jump_take = 1'b0;
    iImm = '0; jImm = '0;
    do_reset();

    // Basic fetch with 3 wait states
    mem_wait = 3;
    irw_before = irw_count;
    fetch_issue(16'h0000, 1'b1, 1'b0, 12'h0);
    wait_idle();
    check("basic_pc", {16'h0, pc}, 32'h0001);
    @(negedge clock); @(negedge clock); #1;
    check("basic_irw_once", irw_count - irw_before, 32'd1);
    check("basic_ir_hold", {16'h0, IR_in}, 32'h1A2B);

    // Back-to-back with mem_ready tied high
    do_reset();
    ready_tied = 1'b1;
    irw_cycles.delete();
    for (int a = 0; a < 4; a++) begin
      exp_addr_q.push_back(16'(a));
      exp_ir_q.push_back(base_word + 16'(a));
    end
    fetch_start = 1'b1;
    repeat (7) @(negedge clock);
    fetch_start = 1'b0;
    wait_idle();
    @(negedge clock); #1;
    ready_tied = 1'b0;
    check("b2b_pc", {16'h0, pc}, 32'h0004);
    check("b2b_count", irw_cycles.size(), 32'd4);
    for (int k = 1; k < irw_cycles.size(); k++)
      check("b2b_gap", irw_cycles[k] - irw_cycles[k-1], 32'd2);

    // Branch in IDLE
    do_reset();
    drive_redirect(1'b0, 6'h0, 1'b1, 12'h010);
    check("jmp_idle_pc", {16'h0, pc}, 32'h0010);
    drive_redirect(1'b1, 6'b111110, 1'b0, 12'h0);
    check("br_idle_pc", {16'h0, pc}, 32'h000E);
    fetch_issue(16'h000E, 1'b1, 1'b0, 12'h0);
    wait_idle();
    check("br_fetch_pc", {16'h0, pc}, 32'h000F);
    drive_redirect(1'b1, 6'd3, 1'b1, 12'h020);
    check("jmp_priority", {16'h0, pc}, 32'h0020);

    // PC wrap: branch -1 from 0 then fetch at FFFF
    do_reset();
    drive_redirect(1'b1, 6'h3F, 1'b0, 12'h0);
    check("br_wrap_pc", {16'h0, pc}, 32'hFFFF);
    mem_wait = $urandom_range(0, 4);
    fetch_issue(16'hFFFF, 1'b1, 1'b0, 12'h0);
    wait_idle();
    check("fetch_wrap_pc", {16'h0, pc}, 32'h0000);

    // Climb to 0x3005, then jump together with fetch
    for (int s = 0; s < 3; s++) begin
      drive_redirect(1'b0, 6'h0, 1'b1, 12'hFFF);
      drive_redirect(1'b1, 6'd1, 1'b0, 12'h0);
    end
    drive_redirect(1'b0, 6'h0, 1'b1, 12'h005);
    check("climb_pc", {16'h0, pc}, 32'h3005);
    mem_wait = $urandom_range(0, 4);
    fetch_issue(16'h30AB, 1'b1, 1'b1, 12'h0AB);
    wait_idle();
    check("jmp_fetch_pc", {16'h0, pc}, 32'h30AC);

    // Redirect during REQ: word discarded, pc = fetch pc + 5
    @(negedge clock); #1;
    ir_before  = IR_in;
    irw_before = irw_count;
    mem_wait   = 6;
    @(negedge clock);
    fetch_issue(16'h30AC, 1'b0, 1'b0, 12'h0);
    check("req_busy", {31'h0, busy}, 32'h1);
    drive_redirect(1'b1, 6'd5, 1'b0, 12'h0);
    check("req_redir_pend", {31'h0, redir_pend_dbg}, 32'h1);
    wait_idle();
    @(negedge clock); #1;
    check("redir_pc", {16'h0, pc}, 32'h30B1);
    check("redir_ir_keep", {16'h0, IR_in}, {16'h0, ir_before});
    check("redir_no_irw", irw_count - irw_before, 32'd0);
    check("redir_clear", {31'h0, redir_pend_dbg}, 32'h0);

    // Later redirect in REQ overwrites the earlier jump
    @(negedge clock);
    fetch_issue(16'h30B1, 1'b0, 1'b0, 12'h0);
    drive_redirect(1'b0, 6'h0, 1'b1, 12'h123);
    drive_redirect(1'b1, 6'd3, 1'b0, 12'h0);
    wait_idle();
    check("redir_overwrite_pc", {16'h0, pc}, 32'h30B4);

    // Reset while a request is outstanding
    mem_wait = 50;
    @(negedge clock);
    irw_before = irw_count;
    fetch_issue(16'h30B4, 1'b0, 1'b0, 12'h0);
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("arst_mem_req", {31'h0, mem_if.mem_req}, 32'h0);
    check("arst_pc", {16'h0, pc}, 32'h0000);
    @(negedge clock);
    do_reset();
    repeat (5) @(negedge clock);
    #1;
    check("arst_no_irw", irw_count - irw_before, 32'd0);

    check("exp_ir_drained", exp_ir_q.size(), 32'd0);
    check("exp_addr_drained", exp_addr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
